cache_wb_ctrl: RTL and testbench
================================

# cache_wb_ctrl

Parametrised, fully-associative, write-back cache controller holding its own tag, data, valid and dirty storage. Sits between the CPU load/store port and the memory-side bus. Adds over the previous controller:
- configurable line count;
- real valid/ready and request/acknowledge handshakes on both sides;
- dirty-victim write-back;
- round-robin replacement;
- optional statistics counters.

## Interface
- NUM_LINES, 4: cache lines (one word each); power of two, ≥2
- ADDR_WIDTH, 8: address width; the full address is the tag
- DATA_WIDTH, 8: word width
- clk  in  1  clock
- reset  in  1  reset, asynchronous, active-high
- cpu_req_valid  in  1  CPU request present
- cpu_req_ready  out  1  controller accepts request; combinational, high only in IDLE
- cpu_req_we  in  1  1 = write, 0 = read
- cpu_req_addr  in  ADDR_WIDTH  request address
- cpu_req_wdata  in  DATA_WIDTH  write data
- cpu_resp_valid  out  1  one-cycle response pulse
- cpu_resp_hit  out  1  request hit; qualified by cpu_resp_valid
- cpu_resp_rdata  out  DATA_WIDTH  read data; held until next response
- mem_req_valid  out  1  memory request
- mem_req_we  out  1  1 = write-back, 0 = fill read
- mem_req_addr  out  ADDR_WIDTH  memory address
- mem_req_wdata  out  DATA_WIDTH  write-back data
- mem_ack  in  1  memory completes current request
- mem_rdata  in  DATA_WIDTH  fill data; valid with mem_ack on reads
- hit_count  out  16  saturating hit counter; present only with CACHE_STATS_EN
- miss_count  out  16  saturating miss counter; present only with CACHE_STATS_EN

## Operation
- **States.** IDLE, LOOKUP, EVICT, FILL, RESPOND.
- **IDLE.** A request is accepted when cpu_req_valid && cpu_req_ready at a clock edge. The edge latches we, addr and wdata, then moves to LOOKUP.
- **LOOKUP.** Compares the latched address against all valid tags.
  - Read hit: rdata is taken from the hit line; go to RESPOND.
  - Write hit: the line data is written and its dirty bit set; go to RESPOND.
  - Miss, victim valid and dirty: go to EVICT.
  - Miss otherwise: a read goes to FILL. A write installs directly: tag set, valid=1, dirty=1, data=wdata, no fill. It then goes to RESPOND.
- **Victim selection.** The lowest-index invalid line is used if one exists. Otherwise the line at the round-robin pointer (log2(NUM_LINES) bits) is used. The pointer increments, wrapping, only when a valid line is replaced.
- **EVICT.**
  - Drives mem_req_valid=1, mem_req_we=1, and the victim's tag and data.
  - On mem_ack, the victim's dirty bit is cleared.
  - Then a read goes to FILL; a write installs as above and goes to RESPOND.
- **FILL.**
  - Drives mem_req_valid=1, mem_req_we=0, mem_req_addr=latched addr.
  - On mem_ack, the victim line is installed: tag, valid=1, dirty=0, data=mem_rdata.
  - cpu_resp_rdata takes mem_rdata; go to RESPOND.
- **RESPOND.** cpu_resp_valid=1 for exactly one cycle, then IDLE. cpu_resp_hit=1 only if LOOKUP hit.
- **Memory side.** mem_ack is ignored when mem_req_valid=0. Write responses leave cpu_resp_rdata unchanged.
- **Reset values.**
  - cpu_req_ready=1.
  - All other outputs 0, including counters.
  - All valid and dirty bits 0; pointer 0.
  - Reset mid-transaction aborts immediately: mem_req_valid drops asynchronously and the in-flight request is lost.

## Timing
- Hit: accept at edge 0; LOOKUP in cycle 1; cpu_resp_valid in cycle 2; ready again in cycle 3.
- Clean read miss: FILL from cycle 2. Response in the cycle after the edge that samples mem_ack.
- Dirty read miss: EVICT from cycle 2. FILL starts the cycle after the ack; then as above.
- Write miss, clean victim: response in cycle 2.
- Write miss, dirty victim: response in the cycle after the write-back ack.
- mem_req_* fields are registered and stable from assertion until the cycle after mem_ack is sampled high. With mem_ack tied high, each memory transaction takes one cycle.
- cpu_req_* inputs are don't-care outside IDLE.

## Configuration
- **Macro:** CACHE_STATS_EN.
- **Defined:** hit_count and miss_count ports exist.
  - A counter increments in LOOKUP on hit or miss respectively.
  - Counters saturate at 16'hFFFF and are cleared by reset.
- **Undefined:** ports and logic are absent; all other behaviour is identical.

## Test plan
- Reset, then read 0x10 with memory returning 0xA5 -> mem read to 0x10. Response hit=0, rdata=0xA5. Re-read 0x10 -> hit=1, rdata=0xA5, no memory request.
- Write 0x20=0x3C (miss, empty cache) -> response in cycle 2, hit=0, no memory traffic. Read 0x20 -> hit=1, rdata=0x3C.
- Fill 4 lines with writes to 0x01..0x04, then read 0x05 -> write-back of 0x01 first (pointer 0), then fill of 0x05. Next miss evicts line 1.
- Dirty miss with mem_ack delayed 3 cycles -> mem_req_valid, addr and wdata held stable throughout; cpu_req_ready=0 until response.
- Assert reset during FILL -> mem_req_valid low immediately, ready=1. Re-read of the same address misses.
- With CACHE_STATS_EN: 3 hits and 2 misses -> hit_count=3, miss_count=2. Preload saturation check: at 16'hFFFF, one further hit leaves 16'hFFFF.

Source files
------------

// File: rtl/cache_wb_ctrl.sv
// cache_wb_ctrl: fully-associative write-back cache with round-robin victims.
// Hit/miss counters are built only when CACHE_STATS_EN is defined.
module cache_wb_ctrl #(
  parameter int NUM_LINES  = 4,
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  cpu_req_valid,
  output logic                  cpu_req_ready,
  input  logic                  cpu_req_we,
  input  logic [ADDR_WIDTH-1:0] cpu_req_addr,
  input  logic [DATA_WIDTH-1:0] cpu_req_wdata,
  output logic                  cpu_resp_valid,
  output logic                  cpu_resp_hit,
  output logic [DATA_WIDTH-1:0] cpu_resp_rdata,
  output logic                  mem_req_valid,
  output logic                  mem_req_we,
  output logic [ADDR_WIDTH-1:0] mem_req_addr,
  output logic [DATA_WIDTH-1:0] mem_req_wdata,
  input  logic                  mem_ack,
  input  logic [DATA_WIDTH-1:0] mem_rdata
`ifdef CACHE_STATS_EN
  ,
  output logic [15:0]           hit_count,
  output logic [15:0]           miss_count
`endif
);

  localparam int IW = (NUM_LINES > 1) ? $clog2(NUM_LINES) : 1;

  typedef enum logic [2:0] {
    IDLE, LOOKUP, EVICT, FILL, RESPOND
  } state_t;

  state_t state_q, state_d;

  logic [ADDR_WIDTH-1:0] tag_q  [NUM_LINES];
  logic [DATA_WIDTH-1:0] data_q [NUM_LINES];
  logic [NUM_LINES-1:0]  valid_q;
  logic [NUM_LINES-1:0]  dirty_q;
  logic [IW-1:0]         rr_q;
  logic [IW-1:0]         vic_q;

  logic                  we_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [DATA_WIDTH-1:0] wdata_q;

  logic          hit;
  logic [IW-1:0] hit_idx;
  logic          free;
  logic [IW-1:0] free_idx;
  logic [IW-1:0] vic;
  logic          vic_dirty;
  logic [IW-1:0] ins_idx;
  logic          ack;

  logic wr_hit;
  logic ins_wr;
  logic ins_fill;
  logic install;
  logic go_evict;
  logic go_fill;
  logic wb_done;

  assign ack       = mem_ack & mem_req_valid;
  assign vic       = free ? free_idx : rr_q;
  assign vic_dirty = valid_q[vic] & dirty_q[vic];
  assign ins_idx   = (state_q == LOOKUP) ? vic : vic_q;
  assign install   = ins_wr | ins_fill;

  assign cpu_req_ready  = (state_q == IDLE);
  assign cpu_resp_valid = (state_q == RESPOND);

  // tag match and lowest-index free line search
  always_comb begin
    hit      = 1'b0;
    hit_idx  = '0;
    free     = 1'b0;
    free_idx = '0;
    for (int i = NUM_LINES - 1; i >= 0; i--) begin
      if (valid_q[i] && tag_q[i] == addr_q) begin
        hit     = 1'b1;
        hit_idx = IW'(i);
      end
      if (!valid_q[i]) begin
        free     = 1'b1;
        free_idx = IW'(i);
      end
    end
  end

  // state register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // next state and per-cycle action strobes
  always_comb begin
    state_d  = state_q;
    wr_hit   = 1'b0;
    ins_wr   = 1'b0;
    ins_fill = 1'b0;
    go_evict = 1'b0;
    go_fill  = 1'b0;
    wb_done  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (cpu_req_valid) state_d = LOOKUP;
      end
      LOOKUP: begin
        if (hit) begin
          state_d = RESPOND;
          wr_hit  = we_q;
        end else if (vic_dirty) begin
          state_d  = EVICT;
          go_evict = 1'b1;
        end else if (we_q) begin
          state_d = RESPOND;
          ins_wr  = 1'b1;
        end else begin
          state_d = FILL;
          go_fill = 1'b1;
        end
      end
      EVICT: begin
        if (ack) begin
          wb_done = 1'b1;
          if (we_q) begin
            state_d = RESPOND;
            ins_wr  = 1'b1;
          end else begin
            state_d = FILL;
            go_fill = 1'b1;
          end
        end
      end
      FILL: begin
        if (ack) begin
          state_d  = RESPOND;
          ins_fill = 1'b1;
        end
      end
      RESPOND: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // tag/data storage; contents are meaningless until valid is set
  always_ff @(posedge clk) begin
    if (wr_hit) data_q[hit_idx] <= wdata_q;
    if (install) begin
      tag_q[ins_idx]  <= addr_q;
      data_q[ins_idx] <= ins_fill ? mem_rdata : wdata_q;
    end
  end

  // request latch, line status, replacement pointer and bus registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      we_q           <= 1'b0;
      addr_q         <= '0;
      wdata_q        <= '0;
      valid_q        <= '0;
      dirty_q        <= '0;
      rr_q           <= '0;
      vic_q          <= '0;
      cpu_resp_hit   <= 1'b0;
      cpu_resp_rdata <= '0;
      mem_req_valid  <= 1'b0;
      mem_req_we     <= 1'b0;
      mem_req_addr   <= '0;
      mem_req_wdata  <= '0;
    end else begin
      if (state_q == IDLE && cpu_req_valid) begin
        we_q    <= cpu_req_we;
        addr_q  <= cpu_req_addr;
        wdata_q <= cpu_req_wdata;
      end
      if (state_q == LOOKUP) begin
        vic_q        <= vic;
        cpu_resp_hit <= hit;
        if (hit && !we_q) cpu_resp_rdata <= data_q[hit_idx];
      end
      if (ins_fill) cpu_resp_rdata <= mem_rdata;
      if (wb_done) dirty_q[vic_q] <= 1'b0;
      if (wr_hit) dirty_q[hit_idx] <= 1'b1;
      if (install) begin
        valid_q[ins_idx] <= 1'b1;
        dirty_q[ins_idx] <= ins_wr;
        if (valid_q[ins_idx]) rr_q <= rr_q + 1'b1;
      end
      if (go_evict) begin
        mem_req_valid <= 1'b1;
        mem_req_we    <= 1'b1;
        mem_req_addr  <= tag_q[vic];
        mem_req_wdata <= data_q[vic];
      end else if (go_fill) begin
        mem_req_valid <= 1'b1;
        mem_req_we    <= 1'b0;
        mem_req_addr  <= addr_q;
      end else if (ack) begin
        mem_req_valid <= 1'b0;
      end
    end
  end

`ifdef CACHE_STATS_EN
  // saturating hit/miss counters, stepped once per lookup
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hit_count  <= '0;
      miss_count <= '0;
    end else if (state_q == LOOKUP) begin
      if (hit) begin
        if (hit_count != 16'hFFFF) hit_count <= hit_count + 16'd1;
      end else begin
        if (miss_count != 16'hFFFF) miss_count <= miss_count + 16'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_cache_wb_ctrl.sv
// tb_cache_wb_ctrl: directed scoreboard bench for cache_wb_ctrl.
// Memory is modelled as word(a) = a ^ 8'hB5 with a programmable ack delay.
module tb_cache_wb_ctrl;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       cpu_req_valid = 1'b0;
  logic       cpu_req_ready;
  logic       cpu_req_we = 1'b0;
  logic [7:0] cpu_req_addr = '0;
  logic [7:0] cpu_req_wdata = '0;
  logic       cpu_resp_valid;
  logic       cpu_resp_hit;
  logic [7:0] cpu_resp_rdata;
  logic       mem_req_valid;
  logic       mem_req_we;
  logic [7:0] mem_req_addr;
  logic [7:0] mem_req_wdata;
  logic       mem_ack = 1'b0;
  logic [7:0] mem_rdata = '0;
`ifdef CACHE_STATS_EN
  logic [15:0] hit_count;
  logic [15:0] miss_count;
`endif

  cache_wb_ctrl #(
    .NUM_LINES(4),
    .ADDR_WIDTH(8),
    .DATA_WIDTH(8)
  ) dut (
    .clk(clk),
    .reset(reset),
    .cpu_req_valid(cpu_req_valid),
    .cpu_req_ready(cpu_req_ready),
    .cpu_req_we(cpu_req_we),
    .cpu_req_addr(cpu_req_addr),
    .cpu_req_wdata(cpu_req_wdata),
    .cpu_resp_valid(cpu_resp_valid),
    .cpu_resp_hit(cpu_resp_hit),
    .cpu_resp_rdata(cpu_resp_rdata),
    .mem_req_valid(mem_req_valid),
    .mem_req_we(mem_req_we),
    .mem_req_addr(mem_req_addr),
    .mem_req_wdata(mem_req_wdata),
    .mem_ack(mem_ack),
    .mem_rdata(mem_rdata)
`ifdef CACHE_STATS_EN
    ,
    .hit_count(hit_count),
    .miss_count(miss_count)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       hit;
    logic [7:0] rdata;
    int         lat;
  } resp_t;

  typedef struct {
    logic       we;
    logic [7:0] addr;
    logic [7:0] wdata;
  } mem_t;

  resp_t sb[$];
  mem_t  exp_mem[$];
  mem_t  mem_log[$];

  int nchk = 0;
  int nfail = 0;
  int ack_delay = 0;
  int wait_cnt = 0;
  int unstable = 0;
  logic have_first = 1'b0;
  mem_t first;
  logic [7:0] last_rd = '0;

  function automatic logic [7:0] mem_word(input logic [7:0] a);
    return a ^ 8'hB5;
  endfunction

  function automatic void check(input string tag,
                                input logic [31:0] obs,
                                input logic [31:0] exp);
    nchk++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endfunction

  // memory responder: acks after ack_delay waiting cycles, logs traffic
  always @(posedge clk) begin
    #1;
    if (reset) begin
      mem_ack = 1'b0;
      wait_cnt = 0;
      have_first = 1'b0;
    end else begin
      if (mem_ack) begin
        mem_ack = 1'b0;
        wait_cnt = 0;
        have_first = 1'b0;
      end
      if (mem_req_valid) begin
        if (!have_first) begin
          first.we = mem_req_we;
          first.addr = mem_req_addr;
          first.wdata = mem_req_wdata;
          have_first = 1'b1;
        end else if (mem_req_we !== first.we ||
                     mem_req_addr !== first.addr ||
                     mem_req_wdata !== first.wdata) begin
          unstable++;
        end
        if (cpu_req_ready) unstable++;
        if (wait_cnt >= ack_delay) begin
          mem_ack = 1'b1;
          mem_rdata = mem_word(mem_req_addr);
          mem_log.push_back(first);
        end else begin
          wait_cnt++;
        end
      end
    end
  end

  task automatic exp_m(input logic we, input logic [7:0] a,
                       input logic [7:0] wd);
    mem_t m;
    m.we = we;
    m.addr = a;
    m.wdata = wd;
    exp_mem.push_back(m);
  endtask

  task automatic apply_reset();
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    last_rd = '0;
  endtask

  task automatic req(input logic we, input logic [7:0] a,
                     input logic [7:0] wd, input logic hit,
                     input logic [7:0] rd, input int ntr);
    resp_t e;
    mem_t  o;
    mem_t  x;
    int    lat;
    logic  busy_ok;
    e.hit = hit;
    e.rdata = we ? last_rd : rd;
    e.lat = 2 + ntr * (ack_delay + 1);
    if (!we) last_rd = rd;
    sb.push_back(e);
    @(negedge clk);
    check("req_ready", cpu_req_ready, 1'b1);
    cpu_req_valid = 1'b1;
    cpu_req_we = we;
    cpu_req_addr = a;
    cpu_req_wdata = wd;
    @(posedge clk);
    #1;
    cpu_req_valid = 1'b0;
    cpu_req_we = 1'b0;
    cpu_req_addr = 8'hFF;
    lat = 1;
    busy_ok = 1'b1;
    while (!cpu_resp_valid && lat < 200) begin
      if (cpu_req_ready) busy_ok = 1'b0;
      @(posedge clk);
      #1;
      lat++;
    end
    if (cpu_req_ready) busy_ok = 1'b0;
    e = sb.pop_front();
    check("resp_valid", cpu_resp_valid, 1'b1);
    check("resp_hit", cpu_resp_hit, e.hit);
    check("resp_rdata", cpu_resp_rdata, e.rdata);
    check("resp_latency", lat, e.lat);
    check("busy_not_ready", busy_ok, 1'b1);
    @(posedge clk);
    #1;
    check("resp_pulse", cpu_resp_valid, 1'b0);
    check("ready_again", cpu_req_ready, 1'b1);
    check("mem_count", mem_log.size(), exp_mem.size());
    while (exp_mem.size() > 0 && mem_log.size() > 0) begin
      x = exp_mem.pop_front();
      o = mem_log.pop_front();
      check("mem_we", o.we, x.we);
      check("mem_addr", o.addr, x.addr);
      if (x.we) check("mem_wdata", o.wdata, x.wdata);
    end
    exp_mem.delete();
    mem_log.delete();
  endtask

  initial begin
    @(negedge clk);
    @(negedge clk);
    check("rst_ready", cpu_req_ready, 1'b1);
    check("rst_resp_valid", cpu_resp_valid, 1'b0);
    check("rst_resp_hit", cpu_resp_hit, 1'b0);
    check("rst_resp_rdata", cpu_resp_rdata, 8'h00);
    check("rst_mem_valid", mem_req_valid, 1'b0);
    check("rst_mem_we", mem_req_we, 1'b0);
    check("rst_mem_addr", mem_req_addr, 8'h00);
    check("rst_mem_wdata", mem_req_wdata, 8'h00);
    reset = 1'b0;

    exp_m(1'b0, 8'h10, 8'h00);
    req(1'b0, 8'h10, 8'h00, 1'b0, 8'hA5, 1);
    req(1'b0, 8'h10, 8'h00, 1'b1, 8'hA5, 0);
    req(1'b1, 8'h20, 8'h3C, 1'b0, 8'h00, 0);
    req(1'b0, 8'h20, 8'h00, 1'b1, 8'h3C, 0);

    apply_reset();
    for (int i = 1; i <= 4; i++)
      req(1'b1, 8'(i), 8'(8'h40 + i), 1'b0, 8'h00, 0);
    exp_m(1'b1, 8'h01, 8'h41);
    exp_m(1'b0, 8'h05, 8'h00);
    req(1'b0, 8'h05, 8'h00, 1'b0, mem_word(8'h05), 2);
    exp_m(1'b1, 8'h02, 8'h42);
    exp_m(1'b0, 8'h06, 8'h00);
    req(1'b0, 8'h06, 8'h00, 1'b0, mem_word(8'h06), 2);

    ack_delay = 3;
    unstable = 0;
    exp_m(1'b1, 8'h03, 8'h43);
    req(1'b1, 8'h07, 8'h77, 1'b0, 8'h00, 1);
    exp_m(1'b1, 8'h04, 8'h44);
    exp_m(1'b0, 8'h08, 8'h00);
    req(1'b0, 8'h08, 8'h00, 1'b0, mem_word(8'h08), 2);
    check("mem_stable", unstable, 0);
    ack_delay = 0;
    req(1'b0, 8'h07, 8'h00, 1'b1, 8'h77, 0);
    req(1'b0, 8'h05, 8'h00, 1'b1, mem_word(8'h05), 0);

    ack_delay = 20;
    @(negedge clk);
    cpu_req_valid = 1'b1;
    cpu_req_we = 1'b0;
    cpu_req_addr = 8'h30;
    @(posedge clk);
    #1;
    cpu_req_valid = 1'b0;
    @(posedge clk);
    #1;
    check("fill_valid", mem_req_valid, 1'b1);
    check("fill_we", mem_req_we, 1'b0);
    check("fill_addr", mem_req_addr, 8'h30);
    #2;
    reset = 1'b1;
    #1;
    check("abort_mem_valid", mem_req_valid, 1'b0);
    check("abort_ready", cpu_req_ready, 1'b1);
    check("abort_resp", cpu_resp_valid, 1'b0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    last_rd = '0;
    ack_delay = 0;
    mem_log.delete();
    exp_m(1'b0, 8'h30, 8'h00);
    req(1'b0, 8'h30, 8'h00, 1'b0, mem_word(8'h30), 1);

`ifdef CACHE_STATS_EN
    apply_reset();
    check("stat_rst_hit", hit_count, 16'd0);
    check("stat_rst_miss", miss_count, 16'd0);
    exp_m(1'b0, 8'h10, 8'h00);
    req(1'b0, 8'h10, 8'h00, 1'b0, 8'hA5, 1);
    for (int i = 0; i < 3; i++)
      req(1'b0, 8'h10, 8'h00, 1'b1, 8'hA5, 0);
    exp_m(1'b0, 8'h11, 8'h00);
    req(1'b0, 8'h11, 8'h00, 1'b0, 8'hA4, 1);
    check("stat_hits", hit_count, 16'd3);
    check("stat_misses", miss_count, 16'd2);
    @(negedge clk);
    force dut.hit_count = 16'hFFFF;
    @(negedge clk);
    release dut.hit_count;
    req(1'b0, 8'h10, 8'h00, 1'b1, 8'hA5, 0);
    check("stat_hit_sat", hit_count, 16'hFFFF);
    check("stat_miss_hold", miss_count, 16'd2);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures",
             nchk, nfail);
    $finish;
  end

endmodule
